// File: rtl/i2s_sample_serializer_pkg.sv
// Shared definitions for the I2S sample serializer: controller state
// encodings and the default sample, slot and bit-clock geometry.
package i2s_sample_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_SAMPLE_W  = 16;
  localparam int DEF_SLOT_BITS = 32;
  localparam int DEF_BCLK_DIV  = 4;

endpackage

// File: rtl/i2s_sample_serializer_bclk_divider.sv
// Bit-clock divider for the I2S serializer. Counts BCLK_DIV clk cycles per
// bclk half-period and flags the cycle whose closing edge drives bclk 1->0.
// Held cleared (div = 0, bclk = 0) whenever run is low.
module bclk_divider
  import i2s_sample_serializer_pkg::*;
#(
  parameter int BCLK_DIV = DEF_BCLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bclk,
  output logic fall
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             term;

  // Next-state for the half-period counter and the bit clock.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    div_d  = div_q;
    bclk_d = bclk_q;
    term   = (div_q == DIV_LAST);
    if (!run) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (term) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Counter and bit-clock registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;
  // The edge closing this cycle is a fall edge; the parent updates on it.
  assign fall = run && term && bclk_q;

endmodule

// File: rtl/i2s_sample_serializer.sv
// I2S sample serializer: latches a mono sample at each frame start, sends it
// MSB-first in both channel slots and pulses new_frame to request the next.
// Build option: I2S_LEFT_JUSTIFIED_EN selects left-justified framing (MSB in
// the same bclk period as the lrclk edge); default is standard I2S with the
// one-bit delay after each lrclk edge.
module i2s_sample_serializer
  import i2s_sample_serializer_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int BCLK_DIV  = DEF_BCLK_DIV
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                new_frame,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int B_W        = $clog2(FRAME_BITS);
  localparam logic [B_W-1:0] LAST_BIT = B_W'(FRAME_BITS - 1);
  localparam logic [B_W-1:0] SLOT_LEN = B_W'(SLOT_BITS);

`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int LAG = 0;
`else
  localparam int LAG = 1;
`endif

  state_e              state_q, state_d;
  logic [B_W-1:0]      b_q, b_d;
  logic [SAMPLE_W-1:0] held_q, held_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                new_frame_q, new_frame_d;

  logic                frame_start;
  logic                load_bit;
  logic [B_W-1:0]      pos;
  logic                bit_val;
  logic                div_run;
  logic                fall;

  assign div_run = (state_q != ST_IDLE);

  bclk_divider #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_divider (
    .clk   (clk),
    .reset (reset),
    .run   (div_run),
    .bclk  (bclk),
    .fall  (fall)
  );

  // Controller, bit index and next serial bit.
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    held_d      = held_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    frame_start = 1'b0;
    load_bit    = 1'b0;
    pos         = '0;
    bit_val     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        b_d     = '0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        if (enable) begin
          state_d     = ST_RUN;
          frame_start = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (state_q == ST_RUN && !enable) begin
          state_d = ST_DRAIN;
        end else if (state_q == ST_DRAIN && enable) begin
          state_d = ST_RUN;
        end
        if (fall) begin
          if (b_q == LAST_BIT) begin
            if (state_q == ST_RUN) begin
              frame_start = 1'b1;
            end else begin
              // Drain complete: park with every output low.
              state_d = ST_IDLE;
              b_d     = '0;
              lrclk_d = 1'b0;
              sdata_d = 1'b0;
            end
          end else begin
            b_d      = b_q + 1'b1;
            load_bit = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_start) begin
      held_d   = sample_in;
      b_d      = '0;
      load_bit = 1'b1;
    end

    // lrclk and sdata present the bit that b_d selects, using the sample
    // being latched on a frame start so the left-justified MSB lands on it.
    if (load_bit) begin
      lrclk_d = (b_d >= SLOT_LEN);
      pos     = lrclk_d ? (b_d - SLOT_LEN) : b_d;
      for (int i = 0; i < SAMPLE_W; i++) begin
        if (int'(pos) == SAMPLE_W - 1 - i + LAG) begin
          bit_val = held_d[i];
        end
      end
      sdata_d = bit_val;
    end

    new_frame_d = frame_start;
  end

  // State, index, held sample and registered pin drivers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: held is a single register, not a memory, so it is reset like any flop.
    if (reset) begin
      state_q     <= ST_IDLE;
      b_q         <= '0;
      held_q      <= '0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      new_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      held_q      <= held_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      new_frame_q <= new_frame_d;
    end
  end

  assign new_frame = new_frame_q;
  assign lrclk     = lrclk_q;
  assign sdata     = sdata_q;

endmodule
